// File: rtl/tuning_inverse_v2_pkg.sv
// Shared widths, FSM encoding and table helpers for the tuning inverse.
// Used by the ROM, the handshake interface and the top.
package tuning_defs;

  localparam int NOTE_W     = 4;
  localparam int TUNE_W     = 15;
  localparam int ROMW       = 22;
  localparam int DIFW       = 17;
  localparam int PHW        = 36;
  localparam int BASE_SHIFT = 13;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SEARCH = 3'd1,
    S_SUB    = 3'd2,
    S_DIV    = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  function automatic logic [PHW-1:0] base_of(
    input logic [ROMW-1:0] lo
  );
    return {1'b0, lo, {BASE_SHIFT{1'b0}}};
  endfunction

  // Low 17 bits of hi-lo equal hi[16:0]-lo[16:0] modulo 2^17.
  function automatic logic [DIFW-1:0] dif_of(
    input logic [ROMW-1:0] hi,
    input logic [ROMW-1:0] lo
  );
    return DIFW'(hi - lo);
  endfunction

endpackage

// File: rtl/tuning_inverse_v2_if.sv
// start/busy/done handshake and result bundle for the tuning inverse.
interface tuning_inverse_v2_if;
  import tuning_defs::*;

  logic              start;
  logic [PHW-1:0]    phase_in;
  logic              busy;
  logic              done;
  logic [NOTE_W-1:0] note_out;
  logic [TUNE_W-1:0] tuning_out;
  logic              sat;
  logic              under;

  modport master (
    output start, phase_in,
    input  busy, done, note_out,
    input  tuning_out, sat, under
  );

  modport slave (
    input  start, phase_in,
    output busy, done, note_out,
    output tuning_out, sat, under
  );

endinterface

// File: rtl/tuning_inverse_v2_rom.sv
// Tuning table: per note a low/high 22-bit word, high equals the
// next note's low so interpolation spans exactly one table step.
module tuning_ROM
  import tuning_defs::*;
(
  input  logic [NOTE_W-1:0] addr,
  output logic [ROMW-1:0]   out_hi,
  output logic [ROMW-1:0]   out_lo
);

  always_comb begin
    out_lo = '0;
    out_hi = '0;
    case (addr)
      4'd0:  begin out_lo = 22'd786432;  out_hi = 22'd847432;  end
      4'd1:  begin out_lo = 22'd847432;  out_hi = 22'd910432;  end
      4'd2:  begin out_lo = 22'd910432;  out_hi = 22'd975432;  end
      4'd3:  begin out_lo = 22'd975432;  out_hi = 22'd1042432; end
      4'd4:  begin out_lo = 22'd1042432; out_hi = 22'd1111432; end
      4'd5:  begin out_lo = 22'd1111432; out_hi = 22'd1182432; end
      4'd6:  begin out_lo = 22'd1182432; out_hi = 22'd1255432; end
      4'd7:  begin out_lo = 22'd1255432; out_hi = 22'd1330432; end
      4'd8:  begin out_lo = 22'd1330432; out_hi = 22'd1407432; end
      4'd9:  begin out_lo = 22'd1407432; out_hi = 22'd1486432; end
      4'd10: begin out_lo = 22'd1486432; out_hi = 22'd1567432; end
      4'd11: begin out_lo = 22'd1567432; out_hi = 22'd1650432; end
      4'd12: begin out_lo = 22'd1650432; out_hi = 22'd1735432; end
      4'd13: begin out_lo = 22'd1735432; out_hi = 22'd1822432; end
      4'd14: begin out_lo = 22'd1822432; out_hi = 22'd1911432; end
      4'd15: begin out_lo = 22'd1911432; out_hi = 22'd2002432; end
      default: begin out_lo = '0; out_hi = '0; end
    endcase
  end

endmodule

// File: rtl/tuning_inverse_v2.sv
// Phase increment -> (note, tuning): binary search over the tuning
// table, then a 15-step restoring divide of the residual.
module tuning_inverse_v2
  import tuning_defs::*;
(
  input  logic           clk,
  input  logic           reset,
  tuning_inverse_v2_if.slave bus
);

  state_e            state_q, state_d;
  logic [PHW-1:0]    p_q, p_d;
  logic [PHW-1:0]    rem_q, rem_d;
  logic [NOTE_W-1:0] idx_q, idx_d;
  logic [NOTE_W-1:0] note_q, note_d;
  logic [1:0]        b_q, b_d;
  logic [3:0]        k_q, k_d;
  logic [TUNE_W-1:0] quo_q, quo_d;
  logic [TUNE_W-1:0] tune_q, tune_d;
  logic              sat_q, sat_d;
  logic              under_q, under_d;

  logic [NOTE_W-1:0] try_idx;
  logic [NOTE_W-1:0] rom_addr;
  logic [ROMW-1:0]   rom_hi;
  logic [ROMW-1:0]   rom_lo;
  logic [PHW-1:0]    base;
  logic [DIFW-1:0]   dif;
  logic [PHW-1:0]    resid;
  logic [PHW-1:0]    sat_lim;
  logic [PHW-1:0]    shifted;
  logic [PHW-1:0]    trial;

  assign try_idx  = idx_q | (NOTE_W'(1) << b_q);
  assign rom_addr = (state_q == S_SEARCH) ? try_idx : idx_q;

  tuning_ROM u_rom (
    .addr   (rom_addr),
    .out_hi (rom_hi),
    .out_lo (rom_lo)
  );

  assign base    = base_of(rom_lo);
  assign dif     = dif_of(rom_hi, rom_lo);
  assign resid   = p_q - base;
  assign sat_lim = PHW'(dif) << TUNE_W;
  assign shifted = PHW'(dif) << k_q;
  assign trial   = rem_q - shifted;

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    rem_d   = rem_q;
    idx_d   = idx_q;
    note_d  = note_q;
    b_d     = b_q;
    k_d     = k_q;
    quo_d   = quo_q;
    tune_d  = tune_q;
    sat_d   = sat_q;
    under_d = under_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          p_d     = bus.phase_in;
          idx_d   = '0;
          b_d     = 2'd3;
          sat_d   = 1'b0;
          under_d = 1'b0;
          state_d = S_SEARCH;
        end
      end
      S_SEARCH: begin
        if (base <= p_q) idx_d = try_idx;
        if (b_q == 2'd0) state_d = S_SUB;
        else             b_d = b_q - 2'd1;
      end
      S_SUB: begin
        // Only idx 0 can sit above P after the search.
        if (base > p_q) begin
          under_d = 1'b1;
          note_d  = '0;
          tune_d  = '0;
          state_d = S_DONE;
        end else if (dif == '0) begin
          note_d  = idx_q;
          tune_d  = '0;
          state_d = S_DONE;
        end else if (resid >= sat_lim) begin
          sat_d   = 1'b1;
          note_d  = idx_q;
          tune_d  = '1;
          state_d = S_DONE;
        end else begin
          rem_d   = resid;
          quo_d   = '0;
          k_d     = 4'd14;
          state_d = S_DIV;
        end
      end
      S_DIV: begin
        if (rem_q >= shifted) begin
          rem_d      = trial;
          quo_d[k_q] = 1'b1;
        end
        if (k_q == 4'd0) begin
          note_d  = idx_q;
          tune_d  = quo_d;
          state_d = S_DONE;
        end else begin
          k_d = k_q - 4'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      p_q     <= '0;
      rem_q   <= '0;
      idx_q   <= '0;
      note_q  <= '0;
      b_q     <= '0;
      k_q     <= '0;
      quo_q   <= '0;
      tune_q  <= '0;
      sat_q   <= 1'b0;
      under_q <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
      note_q  <= note_d;
      b_q     <= b_d;
      k_q     <= k_d;
      quo_q   <= quo_d;
      tune_q  <= tune_d;
      sat_q   <= sat_d;
      under_q <= under_d;
    end
  end

  assign bus.busy       = (state_q == S_SEARCH) ||
                          (state_q == S_SUB) ||
                          (state_q == S_DIV);
  assign bus.done       = (state_q == S_DONE);
  assign bus.note_out   = note_q;
  assign bus.tuning_out = tune_q;
  assign bus.sat        = sat_q;
  assign bus.under      = under_q;

endmodule
